// File: rtl/yarp_data_mem_rsp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : yarp_data_mem_rsp                                            |
// | Description : Word-organised data RAM responder for the yarp core data     |
// |               port: byte-lane steering, range/alignment checking with a    |
// |               sticky first-error capture, configurable read latency.       |
// |               Define YARP_DMEM_PERF_EN to build the load/store counters.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module yarp_data_mem_rsp #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_mem_req_i,
    input  logic [31:0] data_mem_addr_i,
    input  logic [1:0]  data_mem_byte_en_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_mem_wr_data_i,
    output logic [31:0] data_mem_rd_data_o,
    output logic        data_mem_rd_valid_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);

    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [32:0]     w_offset;
    logic            w_in_range;
    logic            w_size_ok;
    logic            w_align_ok;
    logic            w_legal;
    logic            w_ld;
    logic            w_st;
    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic [3:0]      w_be_mask;
    logic [31:0]     w_size_mask;
    logic [31:0]     w_wr_sh;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_ld_data;

    // A 33-bit difference lets the borrow bit flag addresses below the base.
    assign w_offset   = {1'b0, data_mem_addr_i} - {1'b0, BASE_ADDR};
    assign w_in_range = ~w_offset[32] && (w_offset < c_SPAN);
    assign w_idx      = w_offset[c_AW+1:2];
    assign w_lane     = data_mem_addr_i[1:0];

    always_comb begin
        w_size_ok   = 1'b1;
        w_align_ok  = 1'b1;
        w_be_mask   = 4'b0000;
        w_size_mask = 32'h0000_0000;
        case (data_mem_byte_en_i)
            2'b00: begin
                w_be_mask   = 4'b0001 << w_lane;
                w_size_mask = 32'h0000_00FF;
            end
            2'b01: begin
                w_align_ok  = ~data_mem_addr_i[0];
                w_be_mask   = 4'b0011 << w_lane;
                w_size_mask = 32'h0000_FFFF;
            end
            2'b11: begin
                w_align_ok  = (w_lane == 2'b00);
                w_be_mask   = 4'b1111;
                w_size_mask = 32'hFFFF_FFFF;
            end
            default: w_size_ok = 1'b0;
        endcase
    end

    assign w_legal   = w_size_ok & w_align_ok & w_in_range;
    assign w_ld      = data_mem_req_i & ~data_mem_wr_i;
    assign w_st      = data_mem_req_i &  data_mem_wr_i;
    assign w_wr_sh   = data_mem_wr_data_i << {w_lane, 3'b000};
    assign w_rd_word = r_mem[w_idx];
    assign w_ld_data = w_legal ? ((w_rd_word >> {w_lane, 3'b000}) & w_size_mask) : 32'h0;

    // RAM is not reset; reset only suppresses a same-cycle store.
    always_ff @(posedge clk) begin
        if (!reset && w_st && w_legal) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wr_sh[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_rd_comb
            assign data_mem_rd_data_o  = w_ld_data;
            assign data_mem_rd_valid_o = w_ld;
        end else begin : g_rd_reg
            logic [31:0] r_rd_data;
            logic        r_rd_valid;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_data  <= 32'h0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_ld;
                    if (w_ld) begin
                        r_rd_data <= w_ld_data;
                    end
                end
            end
            assign data_mem_rd_data_o  = r_rd_data;
            assign data_mem_rd_valid_o = r_rd_valid;
        end
    endgenerate

    logic        r_err;
    logic [31:0] r_err_addr;

    // An illegal access outranks a clear; the clear re-arms first-error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
        end else if (data_mem_req_i && !w_legal) begin
            r_err <= 1'b1;
            if (!r_err || err_clr_i) begin
                r_err_addr <= data_mem_addr_i;
            end
        end else if (err_clr_i) begin
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;

`ifdef YARP_DMEM_PERF_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_cnt <= 32'h0;
            r_wr_cnt <= 32'h0;
        end else begin
            if (w_ld && w_legal) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_st && w_legal) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end
    assign rd_cnt_o = r_rd_cnt;
    assign wr_cnt_o = r_wr_cnt;
`else
    assign rd_cnt_o = 32'h0;
    assign wr_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire
